krv_flash_arb: RTL and testbench

Two-port arbiter for the shared flash subsystem in krv_e. The instruction-fetch port and the data-load port both read code and constant data from the same flash array. The block grants one requester at a time, issues a single-beat read to the flash, and routes the response back to the owner. It sits between the core's bus interfaces and the flash subsystem, and adds a starvation guard and a response watchdog.

---
 rtl/krv_flash_arb_pkg.sv | 23 ++
 rtl/krv_flash_arb_if.sv | 40 ++++
 rtl/krv_flash_arb_pick.sv | 21 ++
 rtl/krv_flash_arb.sv | 107 ++++++++++
 tb/tb_krv_flash_arb.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/krv_flash_arb_pkg.sv
// Shared types and default sizing for the krv_e two-port flash read arbiter.
package krv_flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IP = 1'b0,
    OWN_DP = 1'b1
  } owner_t;

  localparam int AW_DEF           = 32;
  localparam int DW_DEF           = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF      = 255;

  localparam int STARVE_W = 3;
  localparam int WD_W     = 8;

endpackage

// File: rtl/krv_flash_arb_if.sv
// Bus bundle between the core's fetch/load ports, the arbiter and the flash.
interface krv_flash_arb_if #(
  parameter int AW = krv_flash_arb_pkg::AW_DEF,
  parameter int DW = krv_flash_arb_pkg::DW_DEF
);
  logic          ip_req;
  logic [AW-1:0] ip_addr;
  logic          ip_gnt;
  logic [DW-1:0] ip_rdata;
  logic          ip_rvalid;
  logic          ip_err;

  logic          dp_req;
  logic [AW-1:0] dp_addr;
  logic          dp_gnt;
  logic [DW-1:0] dp_rdata;
  logic          dp_rvalid;
  logic          dp_err;

  logic          fl_req;
  logic [AW-1:0] fl_addr;
  logic [DW-1:0] fl_rdata;
  logic          fl_rvalid;

  // Arbiter view
  modport slave (
    input  ip_req, ip_addr, dp_req, dp_addr, fl_rdata, fl_rvalid,
    output ip_gnt, ip_rdata, ip_rvalid, ip_err,
    output dp_gnt, dp_rdata, dp_rvalid, dp_err,
    output fl_req, fl_addr
  );

  // Requesters and flash as seen from outside the arbiter
  modport master (
    output ip_req, ip_addr, dp_req, dp_addr, fl_rdata, fl_rvalid,
    input  ip_gnt, ip_rdata, ip_rvalid, ip_err,
    input  dp_gnt, dp_rdata, dp_rvalid, dp_err,
    input  fl_req, fl_addr
  );
endinterface

// File: rtl/krv_flash_arb_pick.sv
// Combinational winner selection: dp has priority unless ip has been starved.
module krv_flash_arb_pick
  import krv_flash_arb_pkg::*;
(
  input  logic       en,
  input  logic       ip_req,
  input  logic       dp_req,
  input  logic       starve_hit,
  output owner_t     winner,
  output logic       take,
  output logic [1:0] gnt
);

  always_comb begin
    winner = OWN_DP;
    if (ip_req && (!dp_req || starve_hit)) winner = OWN_IP;
    take = en && (ip_req || dp_req);
    gnt  = {take && (winner == OWN_DP), take && (winner == OWN_IP)};
  end

endmodule

// File: rtl/krv_flash_arb.sv
// Two-port single-beat flash read arbiter with starvation guard and response watchdog.
module krv_flash_arb
  import krv_flash_arb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
)(
  input  logic                  cpu_clk,
  input  logic                  porn,
  krv_flash_arb_if.slave        bus,
  output logic                  busy
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  owner_t              owner_q, winner;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       ip_rdata_q, dp_rdata_q, done_data;
  logic                ip_rvalid_q, ip_err_q, dp_rvalid_q, dp_err_q;
  logic [WD_W-1:0]     wd_q;
  logic [STARVE_W-1:0] starve_q;
  logic                take, done, done_err;
  logic [1:0]          gnt;

  // Grants are gated by reset so nothing is offered while porn is low
  krv_flash_arb_pick u_pick (
    .en        (state_q == IDLE && porn),
    .ip_req    (bus.ip_req),
    .dp_req    (bus.dp_req),
    .starve_hit(starve_q == STARVE_MAX),
    .winner    (winner),
    .take      (take),
    .gnt       (gnt)
  );

  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    done_err  = 1'b0;
    done_data = '0;
    case (state_q)
      IDLE:  if (take) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        // A response in the final watchdog cycle still counts as data
        if (bus.fl_rvalid || wd_q == WD_LAST) begin
          state_d   = IDLE;
          done      = 1'b1;
          done_err  = !bus.fl_rvalid;
          done_data = bus.fl_rvalid ? bus.fl_rdata : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge porn) begin
    if (!porn) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IP;
      addr_q      <= '0;
      wd_q        <= '0;
      starve_q    <= '0;
      ip_rdata_q  <= '0;
      dp_rdata_q  <= '0;
      ip_rvalid_q <= 1'b0;
      ip_err_q    <= 1'b0;
      dp_rvalid_q <= 1'b0;
      dp_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ip_rvalid_q <= done && (owner_q == OWN_IP);
      ip_err_q    <= done && done_err && (owner_q == OWN_IP);
      dp_rvalid_q <= done && (owner_q == OWN_DP);
      dp_err_q    <= done && done_err && (owner_q == OWN_DP);
      if (done && owner_q == OWN_IP) ip_rdata_q <= done_data;
      if (done && owner_q == OWN_DP) dp_rdata_q <= done_data;

      if (state_q == ISSUE)     wd_q <= '0;
      else if (state_q == WAIT) wd_q <= wd_q + 1'b1;

      if (take) begin
        owner_q <= winner;
        addr_q  <= (winner == OWN_DP) ? bus.dp_addr : bus.ip_addr;
        if (winner == OWN_IP) starve_q <= '0;
        else if (bus.ip_req && starve_q != STARVE_MAX) starve_q <= starve_q + 1'b1;
      end
    end
  end

  assign bus.ip_gnt    = gnt[0];
  assign bus.dp_gnt    = gnt[1];
  assign bus.ip_rdata  = ip_rdata_q;
  assign bus.ip_rvalid = ip_rvalid_q;
  assign bus.ip_err    = ip_err_q;
  assign bus.dp_rdata  = dp_rdata_q;
  assign bus.dp_rvalid = dp_rvalid_q;
  assign bus.dp_err    = dp_err_q;
  assign bus.fl_req    = (state_q == ISSUE);
  assign bus.fl_addr   = addr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_krv_flash_arb.sv
// Bench for krv_flash_arb: directed scenarios plus random traffic against a transaction-level model.
module tb_krv_flash_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic porn = 1'b0;
  logic busy;

  krv_flash_arb_if #(.AW(AW), .DW(DW)) bus ();

  krv_flash_arb #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .cpu_clk(clk),
    .porn   (porn),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding read, tracked by its grant cycle rather than by FSM state
  int             mc = 0;
  bit             m_act = 0, m_own = 0, m_cv = 0, m_cown = 0, m_cerr = 0;
  int             m_g = 0, m_starve = 0;
  logic [AW-1:0]  m_addr = '0;
  logic [DW-1:0]  m_rd_ip = '0, m_rd_dp = '0;

  always @(negedge clk) begin : model
    bit e_ig, e_dg, e_fr, e_iv, e_dv;
    mc++;
    if (!porn) begin
      m_act = 0; m_cv = 0; m_starve = 0;
      m_addr = '0; m_rd_ip = '0; m_rd_dp = '0;
    end
    e_ig = porn && !m_act && bus.ip_req && (!bus.dp_req || m_starve == STARVE_LIMIT);
    e_dg = porn && !m_act && bus.dp_req && !e_ig;
    e_fr = m_act && (mc == m_g + 1);
    e_iv = m_cv && !m_cown;
    e_dv = m_cv && m_cown;
    chk("m_ip_gnt", bus.ip_gnt, e_ig);
    chk("m_dp_gnt", bus.dp_gnt, e_dg);
    chk("m_fl_req", bus.fl_req, e_fr);
    chk("m_busy", busy, m_act);
    chk("m_fl_addr", bus.fl_addr, m_addr);
    chk("m_ip_rvalid", bus.ip_rvalid, e_iv);
    chk("m_ip_err", bus.ip_err, e_iv && m_cerr);
    chk("m_dp_rvalid", bus.dp_rvalid, e_dv);
    chk("m_dp_err", bus.dp_err, e_dv && m_cerr);
    chk("m_ip_rdata", bus.ip_rdata, m_rd_ip);
    chk("m_dp_rdata", bus.dp_rdata, m_rd_dp);
    if (porn) begin
      m_cv = 0;
      if (m_act) begin
        if ((mc >= m_g + 2 && bus.fl_rvalid) || mc == m_g + TIMEOUT + 1) begin
          m_act = 0; m_cv = 1; m_cown = m_own; m_cerr = !bus.fl_rvalid;
          if (m_own) m_rd_dp = bus.fl_rvalid ? bus.fl_rdata : '0;
          else       m_rd_ip = bus.fl_rvalid ? bus.fl_rdata : '0;
        end
      end else if (e_ig || e_dg) begin
        m_act = 1; m_g = mc; m_own = e_dg;
        m_addr = e_dg ? bus.dp_addr : bus.ip_addr;
        if (e_ig) m_starve = 0;
        else if (bus.ip_req && m_starve < STARVE_LIMIT) m_starve++;
      end
    end
  end

  // Driver state: requesters drop req after gnt, flash answers flash_lat cycles after fl_req
  int            cnow = 0, resp_at = -1, flash_lat = 0;
  bit            rnd_flash = 0, use_fix = 0;
  bit            saw_ip_gnt = 0, saw_dp_gnt = 0;
  logic [DW-1:0] fix_data = '0, resp_val = '0;

  task automatic begin_cyc();
    @(posedge clk); #1;
    cnow++;
    if (saw_ip_gnt) bus.ip_req = 1'b0;
    if (saw_dp_gnt) bus.dp_req = 1'b0;
    bus.fl_rvalid = 1'b0;
    if (rnd_flash) begin
      bus.fl_rvalid = ($urandom_range(2) == 0);
      bus.fl_rdata  = $urandom;
    end else if (cnow == resp_at) begin
      bus.fl_rvalid = 1'b1;
      bus.fl_rdata  = resp_val;
    end
  endtask

  task automatic end_cyc();
    @(negedge clk); #1;
    saw_ip_gnt = bus.ip_gnt;
    saw_dp_gnt = bus.dp_gnt;
    if (bus.fl_req && flash_lat > 0) begin
      resp_at  = cnow + flash_lat;
      resp_val = use_fix ? fix_data : ($urandom | 32'h1);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      begin_cyc(); end_cyc(); n++;
    end while ((bus.ip_req || bus.dp_req || busy) && n < 600);
    chk(name, {bus.ip_req, bus.dp_req, busy}, 3'b000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int g, n, grants;
    logic [9:0] order;
    bus.ip_req = 0; bus.ip_addr = '0; bus.dp_req = 0; bus.dp_addr = '0;
    bus.fl_rvalid = 0; bus.fl_rdata = '0;
    order = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_fl_req", bus.fl_req, 0);
    chk("rst_fl_addr", bus.fl_addr, 0);
    chk("rst_ip_rdata", bus.ip_rdata, 0);
    begin_cyc(); porn = 1'b1; end_cyc();

    // Single ip read, flash answers two cycles after fl_req
    flash_lat = 2; use_fix = 1; fix_data = 32'hDEADBEEF;
    begin_cyc(); bus.ip_req = 1; bus.ip_addr = 32'h48; end_cyc();
    chk("t1_ip_gnt", bus.ip_gnt, 1);
    chk("t1_dp_gnt", bus.dp_gnt, 0);
    begin_cyc(); end_cyc();
    chk("t1_fl_req", bus.fl_req, 1);
    chk("t1_fl_addr", bus.fl_addr, 32'h48);
    begin_cyc(); end_cyc();
    chk("t1_busy", busy, 1);
    begin_cyc(); end_cyc();
    chk("t1_not_early", bus.ip_rvalid, 0);
    begin_cyc(); end_cyc();
    chk("t1_ip_rvalid", bus.ip_rvalid, 1);
    chk("t1_ip_rdata", bus.ip_rdata, 32'hDEADBEEF);
    chk("t1_ip_err", bus.ip_err, 0);
    chk("t1_dp_rvalid", bus.dp_rvalid, 0);
    use_fix = 0;
    wait_idle("t1_drain");

    // Contested priority with single-cycle flash
    flash_lat = 1; grants = 0; n = 0;
    while (grants < 10 && n < 100) begin
      begin_cyc(); bus.ip_req = 1; bus.dp_req = 1; end_cyc(); n++;
      if (bus.ip_gnt || bus.dp_gnt) begin
        order[grants] = bus.dp_gnt;
        grants++;
      end
    end
    chk("t2_order", order, 10'b0111101111);
    wait_idle("t2_drain");

    // Timeout with a silent flash, then a late response
    flash_lat = 0;
    begin_cyc(); bus.dp_req = 1; bus.dp_addr = 32'h100; end_cyc(); g = cnow;
    chk("t3_dp_gnt", bus.dp_gnt, 1);
    chk("t3_pre_rdata_nz", (bus.dp_rdata != 0), 1);
    while (cnow < g + 257) begin begin_cyc(); end_cyc(); end
    chk("t3_dp_rvalid", bus.dp_rvalid, 1);
    chk("t3_dp_err", bus.dp_err, 1);
    chk("t3_dp_rdata", bus.dp_rdata, 0);
    begin_cyc(); end_cyc();
    chk("t3_idle", busy, 0);
    while (cnow < g + 259) begin begin_cyc(); end_cyc(); end
    begin_cyc(); bus.fl_rvalid = 1; bus.fl_rdata = 32'hCAFE; end_cyc();
    begin_cyc(); end_cyc();
    chk("t3_late_dp", bus.dp_rvalid, 0);
    chk("t3_late_ip", bus.ip_rvalid, 0);

    // Response in the same cycle the watchdog expires
    begin_cyc(); bus.dp_req = 1; bus.dp_addr = 32'h200; end_cyc(); g = cnow;
    while (cnow < g + 255) begin begin_cyc(); end_cyc(); end
    begin_cyc(); bus.fl_rvalid = 1; bus.fl_rdata = 32'h1234; end_cyc();
    begin_cyc(); end_cyc();
    chk("t4_dp_rvalid", bus.dp_rvalid, 1);
    chk("t4_dp_err", bus.dp_err, 0);
    chk("t4_dp_rdata", bus.dp_rdata, 32'h1234);

    // Reset in WAIT after four contested dp grants
    flash_lat = 1; grants = 0; n = 0;
    while (grants < 4 && n < 100) begin
      begin_cyc(); bus.ip_req = 1; bus.dp_req = 1; end_cyc(); n++;
      if (bus.dp_gnt) grants++;
    end
    chk("t5_setup", grants, 4);
    flash_lat = 0;
    begin_cyc(); bus.dp_req = 0; end_cyc();
    begin_cyc(); end_cyc();
    begin_cyc(); porn = 0; bus.ip_req = 0; bus.fl_rvalid = 1; bus.fl_rdata = 32'h5555; end_cyc();
    chk("t5_busy", busy, 0);
    chk("t5_rdata_clr", bus.dp_rdata, 0);
    begin_cyc(); bus.fl_rvalid = 1; end_cyc();
    chk("t5_no_rv_rst", bus.dp_rvalid, 0);
    begin_cyc(); porn = 1; end_cyc();
    chk("t5_no_pulse", bus.dp_rvalid, 0);
    flash_lat = 1;
    begin_cyc(); bus.ip_req = 1; bus.dp_req = 1; end_cyc();
    chk("t5_starve_clr", bus.dp_gnt, 1);
    repeat (6) begin begin_cyc(); end_cyc(); end
    chk("t5_ip_rvalid", bus.ip_rvalid, 1);
    chk("t5_ip_err", bus.ip_err, 0);
    wait_idle("t5_drain");

    // Uncontested dp stream must not advance the starve count
    for (int i = 0; i < 10; i++) begin
      begin_cyc(); bus.dp_req = 1; bus.dp_addr = $urandom; end_cyc();
      wait_idle("t6_drain");
    end
    begin_cyc(); bus.ip_req = 1; bus.dp_req = 1; end_cyc();
    chk("t6_dp_wins", bus.dp_gnt, 1);
    wait_idle("t6_end");

    // Random traffic with a randomly strobing flash
    rnd_flash = 1;
    repeat (3000) begin
      begin_cyc();
      if (!bus.ip_req && $urandom_range(3) == 0) begin bus.ip_req = 1; bus.ip_addr = $urandom; end
      if (!bus.dp_req && $urandom_range(3) == 0) begin bus.dp_req = 1; bus.dp_addr = $urandom; end
      end_cyc();
    end
    rnd_flash = 0;
    wait_idle("rnd_drain");

    repeat (2) begin begin_cyc(); end_cyc(); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
